// File: rtl/sort_net_pipe.sv
// Pipelined bitonic sorting network: N = 2**LOG_N unsigned keys per transaction,
// one registered compare-exchange layer per stage, each output key tagged with its source lane.
module sort_net_pipe #(
    parameter int WIDTH = 32,
    parameter int LOG_N = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [(2**LOG_N)*WIDTH-1:0]   in_data,
    input  logic                          in_desc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [(2**LOG_N)*WIDTH-1:0]   out_data,
    output logic [(2**LOG_N)*LOG_N-1:0]   out_idx,
    output logic                          out_desc
);

    localparam int N = 2 ** LOG_N;
    localparam int S = LOG_N * (LOG_N + 1) / 2;

    typedef logic [WIDTH-1:0] key_t;
    typedef logic [LOG_N-1:0] tag_t;

    // Stage registers: stage l holds the result of compare-exchange layer l.
    key_t key_q [S][N];
    tag_t tag_q [S][N];
    logic desc_q  [S];
    logic valid_q [S];

    // Layer inputs (previous stage or the input port) and layer outputs.
    key_t src_key [S][N];
    tag_t src_tag [S][N];
    logic src_desc [S];
    key_t key_d [S][N];
    tag_t tag_d [S][N];

    logic advance;

    // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
    // moves together (global stall); in_ready is combinational so an accepted input
    // always has a free stage-0 slot, and out_valid only drops after a transfer.
    assign advance  = !valid_q[S-1] || out_ready;
    assign in_ready = advance;

    // Strict precedence on the composite {key, tag}; the key order flips in
    // descending mode while equal keys always keep the lower source lane first.
    function automatic logic prec(input key_t ka, input tag_t ta,
                                  input key_t kb, input tag_t tb,
                                  input logic desc);
        if (ka != kb) begin
            return desc ? (ka > kb) : (ka < kb);
        end
        return ta < tb;
    endfunction

    for (genvar l = 0; l < S; l++) begin : g_src
        for (genvar i = 0; i < N; i++) begin : g_lane
            if (l == 0) begin : g_first
                assign src_key[l][i] = in_data[i*WIDTH +: WIDTH];
                assign src_tag[l][i] = tag_t'(i);
            end else begin : g_rest
                assign src_key[l][i] = key_q[l-1][i];
                assign src_tag[l][i] = tag_q[l-1][i];
            end
        end
        if (l == 0) begin : g_desc_first
            assign src_desc[l] = in_desc;
        end else begin : g_desc_rest
            assign src_desc[l] = desc_q[l-1];
        end
    end

    // Merge phase k builds sorted runs of 2**(k+1); its layers use distances 2**k down to 1.
    for (genvar k = 0; k < LOG_N; k++) begin : g_merge
        for (genvar jj = 0; jj <= k; jj++) begin : g_layer
            localparam int L = k * (k + 1) / 2 + jj;
            localparam int D = 1 << (k - jj);
            for (genvar i = 0; i < N; i++) begin : g_lane
                if ((i & D) == 0) begin : g_cx
                    // Alternate run directions so each pair of runs forms a bitonic sequence.
                    localparam bit UP = ((i >> (k + 1)) & 1) == 0;
                    logic prec_ab;
                    logic swap;
                    assign prec_ab = prec(src_key[L][i], src_tag[L][i],
                                          src_key[L][i+D], src_tag[L][i+D], src_desc[L]);
                    assign swap = UP ? !prec_ab : prec_ab;
                    assign key_d[L][i]   = swap ? src_key[L][i+D] : src_key[L][i];
                    assign key_d[L][i+D] = swap ? src_key[L][i]   : src_key[L][i+D];
                    assign tag_d[L][i]   = swap ? src_tag[L][i+D] : src_tag[L][i];
                    assign tag_d[L][i+D] = swap ? src_tag[L][i]   : src_tag[L][i+D];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < S; l++) begin
                valid_q[l] <= 1'b0;
                desc_q[l]  <= 1'b0;
                for (int i = 0; i < N; i++) begin
                    key_q[l][i] <= '0;
                    tag_q[l][i] <= '0;
                end
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            // Input payload is only captured on an actual transfer.
            if (in_valid) begin
                desc_q[0] <= in_desc;
                for (int i = 0; i < N; i++) begin
                    key_q[0][i] <= key_d[0][i];
                    tag_q[0][i] <= tag_d[0][i];
                end
            end
            for (int l = 1; l < S; l++) begin
                valid_q[l] <= valid_q[l-1];
                desc_q[l]  <= desc_q[l-1];
                for (int i = 0; i < N; i++) begin
                    key_q[l][i] <= key_d[l][i];
                    tag_q[l][i] <= tag_d[l][i];
                end
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign out_data[j*WIDTH +: WIDTH] = key_q[S-1][j];
        assign out_idx[j*LOG_N +: LOG_N]  = tag_q[S-1][j];
    end
    assign out_valid = valid_q[S-1];
    assign out_desc  = desc_q[S-1];

endmodule

// File: tb/tb_sort_net_pipe.sv
// Bench for sort_net_pipe: directed table on the default 8x32 instance, handshake and
// reset sequences, and a random sweep over three further parameter sets.
module tb_sort_net_pipe;

    localparam int W  = 32;
    localparam int LG = 3;
    localparam int N  = 8;
    localparam int S  = 6;

    typedef logic [31:0] karr_t [32];
    typedef int          iarr_t [32];

    typedef struct {
        logic [255:0] data;
        logic         desc;
        logic [255:0] exp_data;
        logic [23:0]  exp_idx;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid, in_ready, in_desc;
    logic [N*W-1:0]   in_data;
    logic             out_valid, out_ready, out_desc;
    logic [N*W-1:0]   out_data;
    logic [N*LG-1:0]  out_idx;

    sort_net_pipe #(.WIDTH(W), .LOG_N(LG)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_desc(out_desc)
    );

    logic sw_ready;
    logic a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_desc;
    logic [1:0] a_in_data, a_out_data, a_out_idx;
    logic b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_desc;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_out_idx;
    logic c_in_valid, c_in_ready, c_in_desc, c_out_valid, c_out_desc;
    logic [255:0] c_in_data, c_out_data;
    logic [159:0] c_out_idx;

    sort_net_pipe #(.WIDTH(1), .LOG_N(1)) u_sw_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_desc(a_in_desc), .out_valid(a_out_valid),
        .out_ready(sw_ready), .out_data(a_out_data), .out_idx(a_out_idx), .out_desc(a_out_desc)
    );
    sort_net_pipe #(.WIDTH(8), .LOG_N(2)) u_sw_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_desc(b_in_desc), .out_valid(b_out_valid),
        .out_ready(sw_ready), .out_data(b_out_data), .out_idx(b_out_idx), .out_desc(b_out_desc)
    );
    sort_net_pipe #(.WIDTH(8), .LOG_N(5)) u_sw_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_desc(c_in_desc), .out_valid(c_out_valid),
        .out_ready(sw_ready), .out_data(c_out_data), .out_idx(c_out_idx), .out_desc(c_out_desc)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q  [$];
    logic [255:0] expi_q [$];
    logic         expd_q [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [23:0] pi(input logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Stable insertion sort: equal keys keep source-lane order in both modes.
    function automatic void ref_sort(input karr_t k, input int n, input bit desc,
                                     output karr_t sk, output iarr_t si);
        for (int i = 0; i < 32; i++) begin
            sk[i] = '0;
            si[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            int j = i;
            while (j > 0 && (desc ? (k[i] > sk[j-1]) : (k[i] < sk[j-1]))) begin
                sk[j] = sk[j-1];
                si[j] = si[j-1];
                j--;
            end
            sk[j] = k[i];
            si[j] = i;
        end
    endfunction

    function automatic void expect_pack(input logic [255:0] vec, input int n, input int w,
                                        input int lg, input bit desc,
                                        output logic [255:0] ed, output logic [255:0] ei);
        karr_t k;
        karr_t sk;
        iarr_t si;
        logic [31:0] t;
        for (int j = 0; j < 32; j++) k[j] = '0;
        for (int j = 0; j < n; j++)
            for (int b = 0; b < w; b++) k[j][b] = vec[j*w + b];
        ref_sort(k, n, desc, sk, si);
        ed = '0;
        ei = '0;
        for (int j = 0; j < n; j++) begin
            t = si[j];
            for (int b = 0; b < w; b++) ed[j*w + b] = sk[j][b];
            for (int b = 0; b < lg; b++) ei[j*lg + b] = t[b];
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Single transaction from an idle pipe with out_ready held high; checks exact latency.
    task automatic run_vec(input vec_t v, input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v.data;
        in_desc   = v.desc;
        #1;
        check({tag, " in_ready"}, 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '1;
        in_desc  = ~v.desc;
        for (int c = 1; c < S; c++) begin
            check({tag, " early out_valid"}, 256'(out_valid), 256'(0));
            @(posedge clk); #1;
        end
        check({tag, " out_valid"}, 256'(out_valid), 256'(1));
        check({tag, " out_data"}, out_data, v.exp_data);
        check({tag, " out_idx"}, 256'(out_idx), 256'(v.exp_idx));
        check({tag, " out_desc"}, 256'(out_desc), 256'(v.desc));
        @(posedge clk); #1;
    endtask

    task automatic run_backpressure();
        int sent = 0;
        int got = 0;
        bit have_cur = 0;
        bit prev_stall = 0;
        logic [255:0] cur_d, sv_d, sv_i, ed, ei;
        logic cur_desc, sv_desc, in_x, out_x;
        exp_q.delete(); expi_q.delete(); expd_q.delete();
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            if (prev_stall) begin
                check("bp stall valid", 256'(out_valid), 256'(1));
                check("bp stall data", out_data, sv_d);
                check("bp stall idx", 256'(out_idx), sv_i);
                check("bp stall desc", 256'(out_desc), 256'(sv_desc));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                if (!have_cur) begin
                    for (int j = 0; j < N; j++)
                        cur_d[j*W +: W] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
                    cur_desc = 1'($urandom_range(0, 1));
                    have_cur = 1;
                end
                in_valid = 1'b1;
                in_data  = cur_d;
                in_desc  = cur_desc;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp in_ready rule", 256'(in_ready), 256'(!out_valid || out_ready));
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected output", 256'(1), 256'(0));
                end else begin
                    check("bp data", out_data, exp_q.pop_front());
                    check("bp idx", 256'(out_idx), expi_q.pop_front());
                    check("bp desc", 256'(out_desc), 256'(expd_q.pop_front()));
                end
                got++;
            end
            if (in_x) begin
                expect_pack(cur_d, N, W, LG, cur_desc, ed, ei);
                exp_q.push_back(ed);
                expi_q.push_back(ei);
                expd_q.push_back(cur_desc);
                sent++;
                have_cur = 0;
            end
            prev_stall = out_valid && !out_ready;
            sv_d = out_data;
            sv_i = 256'(out_idx);
            sv_desc = out_desc;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp sent count", 256'(sent), 256'(20));
        check("bp received count", 256'(got), 256'(20));
        for (int c = 0; c < S + 2; c++) begin
            @(posedge clk); #1;
        end
        check("bp drained valid", 256'(out_valid), 256'(0));
        check("bp leftover expected", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic run_sweep(input int sel);
        int n, w, lg, s;
        logic [255:0] gd, ed, ei, od, oi;
        logic dd, ov, odesc, exp_v;
        logic [31:0] mask;
        string nm;
        n  = (sel == 0) ? 2 : (sel == 1) ? 4 : 32;
        w  = (sel == 0) ? 1 : 8;
        lg = (sel == 0) ? 1 : (sel == 1) ? 2 : 5;
        s  = lg * (lg + 1) / 2;
        nm = (sel == 0) ? "sweep n2w1" : (sel == 1) ? "sweep n4w8" : "sweep n32w8";
        mask = (32'd1 << w) - 32'd1;
        exp_q.delete(); expi_q.delete(); expd_q.delete();
        for (int c = 0; c < 1000 + s + 1; c++) begin
            if (c < 1000) begin
                gd = '0;
                for (int j = 0; j < n; j++) begin
                    logic [31:0] r;
                    r = $urandom & mask;
                    for (int b = 0; b < w; b++) gd[j*w + b] = r[b];
                end
                dd = 1'($urandom_range(0, 1));
                expect_pack(gd, n, w, lg, dd, ed, ei);
                exp_q.push_back(ed);
                expi_q.push_back(ei);
                expd_q.push_back(dd);
            end
            case (sel)
                0: begin a_in_valid = (c < 1000); a_in_data = gd[1:0];   a_in_desc = dd; end
                1: begin b_in_valid = (c < 1000); b_in_data = gd[31:0];  b_in_desc = dd; end
                default: begin c_in_valid = (c < 1000); c_in_data = gd; c_in_desc = dd; end
            endcase
            #1;
            case (sel)
                0: begin ov = a_out_valid; od = 256'(a_out_data); oi = 256'(a_out_idx); odesc = a_out_desc; end
                1: begin ov = b_out_valid; od = 256'(b_out_data); oi = 256'(b_out_idx); odesc = b_out_desc; end
                default: begin ov = c_out_valid; od = c_out_data; oi = 256'(c_out_idx); odesc = c_out_desc; end
            endcase
            exp_v = (c >= s) && (c - s < 1000);
            check({nm, " out_valid"}, 256'(ov), 256'(exp_v));
            if (ov && exp_v) begin
                check({nm, " data"}, od, exp_q.pop_front());
                check({nm, " idx"}, oi, expi_q.pop_front());
                check({nm, " desc"}, 256'(odesc), 256'(expd_q.pop_front()));
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [4];

    initial begin
        void'($urandom(32'd1234));
        tbl[0].data     = pk(7, 3, 9, 1, 8, 2, 6, 4);
        tbl[0].desc     = 1'b0;
        tbl[0].exp_data = pk(1, 2, 3, 4, 6, 7, 8, 9);
        tbl[0].exp_idx  = pi(3, 5, 1, 7, 6, 0, 4, 2);
        tbl[1].data     = pk(5, 5, 0, 32'hFFFFFFFF, 5, 0, 1, 1);
        tbl[1].desc     = 1'b1;
        tbl[1].exp_data = pk(32'hFFFFFFFF, 5, 5, 5, 1, 1, 0, 0);
        tbl[1].exp_idx  = pi(3, 0, 1, 4, 6, 7, 2, 5);
        tbl[2].data     = pk(42, 42, 42, 42, 42, 42, 42, 42);
        tbl[2].desc     = 1'b1;
        tbl[2].exp_data = pk(42, 42, 42, 42, 42, 42, 42, 42);
        tbl[2].exp_idx  = pi(0, 1, 2, 3, 4, 5, 6, 7);
        tbl[3].data     = pk(0, 1, 2, 3, 4, 5, 6, 7);
        tbl[3].desc     = 1'b1;
        tbl[3].exp_data = pk(7, 6, 5, 4, 3, 2, 1, 0);
        tbl[3].exp_idx  = pi(7, 6, 5, 4, 3, 2, 1, 0);

        sw_ready   = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_desc = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_desc = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_in_desc = 1'b0;

        // Reset held two cycles while a transaction is offered.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = tbl[0].data;
        in_desc   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset out_valid", 256'(out_valid), 256'(0));
        check("reset in_ready", 256'(in_ready), 256'(1));
        check("reset out_data", out_data, 256'(0));
        check("reset out_idx", 256'(out_idx), 256'(0));
        check("reset out_desc", 256'(out_desc), 256'(0));
        for (int c = 0; c < S + 1; c++) begin
            @(posedge clk); #1;
            check("reset no transfer", 256'(out_valid), 256'(0));
        end

        for (int t = 0; t < 4; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        run_backpressure();

        // Four transactions in flight, then a one-cycle reset.
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_data  = tbl[t].data;
            in_desc  = tbl[t].desc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset out_valid", 256'(out_valid), 256'(0));
        for (int c = 0; c < S + 2; c++) begin
            @(posedge clk); #1;
            check("midreset flushed", 256'(out_valid), 256'(0));
        end
        run_vec(tbl[1], "after midreset");

        for (int sel = 0; sel < 3; sel++) run_sweep(sel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_net_pipe.md
# sort_net_pipe

Pipelined, parametrised bitonic sorting network with a valid/ready handshake. It sorts N = 2**LOG_N unsigned keys of WIDTH bits per transaction, in ascending or descending order chosen per transaction. Each output key carries the lane index it came from. It replaces the fixed 4×32-bit combinational sorter where throughput and clock rate matter, and it feeds downstream consumers that need a permutation (top-k, merge units).

## Interface
Parameters:
- WIDTH, 32, key width in bits (≥1)
- LOG_N, 3, log2 of lane count; N = 2**LOG_N, legal 1..5

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts the input this cycle
- in_data  in  N*WIDTH  lane i = bits [(i+1)*WIDTH-1 : i*WIDTH]
- in_desc  in  1  0 = ascending (lane 0 smallest), 1 = descending (lane 0 largest)
- out_valid  out  1  sorted result present
- out_ready  in  1  downstream accepts the result
- out_data  out  N*WIDTH  sorted keys, same lane packing as in_data
- out_idx  out  N*LOG_N  lane j = original input lane of out_data lane j
- out_desc  out  1  in_desc of this transaction, carried through

## Operation
- Network: standard bitonic sort, S = LOG_N*(LOG_N+1)/2 compare-exchange layers. Each layer is registered, and each stage holds {keys, idx tags, desc, valid}.
- On acceptance, lane i's tag is set to i.
- Comparison is on the composite {key, tag}, which gives a total order with no ties. Among equal keys, the lower original lane always exits at the lower output lane in both modes, so the sort is stable in ascending mode and deterministic in descending mode.
- Descending mode: the key ordering is inverted per layer, and the tag tie-break stays ascending.
- Keys are unsigned. No arithmetic is performed, so there is no width growth.
- Pipeline control is a global stall: advance = !out_valid || out_ready.
  - On advance, every stage loads from its predecessor. Stage 0 loads in_valid && in_ready.
  - When advance is low, all stages hold.
- in_ready = advance, a combinational function of out_valid and out_ready. It is never registered.
- Bubbles are not compressed. An invalid stage still occupies a slot and moves with the pipe.
- out_* are driven directly from the last stage's registers. out_data, out_idx and out_desc hold stable while out_valid && !out_ready.
- Handshake rules:
  - A transfer occurs when valid && ready on the same edge.
  - in_data and in_desc are sampled only on transfer.
  - out_valid does not drop without a transfer.
- Reset:
  - rst clears every stage valid bit. out_valid = 0 and in_ready = 1 in the cycle after reset.
  - out_data, out_idx and out_desc reset to 0.
  - Reset mid-operation discards all in-flight transactions. Any transaction presented in the reset cycle is not accepted.
- LOG_N = 1 degenerates to a single compare-exchange with S = 1.

## Timing
- Latency: S cycles from input transfer to out_valid, with no stalls. Defaults give S = 6; LOG_N = 2 gives S = 3.
- Throughput: one transaction per cycle while out_ready = 1.
- A stall of k cycles delays every in-flight result by exactly k.
- Capacity: S transactions in flight, with no internal buffering beyond the stage registers.
- Critical path: one WIDTH+LOG_N comparator plus a 2:1 swap mux per stage, plus the out_ready → in_ready fan-out.
- Simultaneous out_ready deassertion and in_valid in the same cycle: in_ready = 0 and nothing is accepted.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 2 cycles with in_valid = 1.
  - Required response: no transfer; out_valid = 0, in_ready = 1, out_data = 0 after reset.
- Basic ascending, defaults:
  - Stimulus: in_data lanes 0..7 = {7,3,9,1,8,2,6,4}, in_desc = 0, out_ready = 1.
  - Required response: exactly 6 cycles later out_data = {1,2,3,4,6,7,8,9}, out_idx = {3,5,1,7,6,0,4,2}, out_desc = 0.
- Descending with duplicates:
  - Stimulus: {5,5,0,FFFFFFFF,5,0,1,1}, in_desc = 1.
  - Required response: out_data = {FFFFFFFF,5,5,5,1,1,0,0}, out_idx = {3,0,1,4,6,7,2,5}.
- Back-to-back with backpressure:
  - Stimulus: 20 random transactions on consecutive cycles, out_ready toggling randomly (seeded).
  - Required response: results match a reference model, in order, with none lost or duplicated. Outputs are stable during every stall, and in_ready = !out_valid || out_ready on every cycle.
- Mid-flight reset:
  - Stimulus: 4 transactions in flight; assert rst for 1 cycle.
  - Required response: out_valid = 0 the next cycle. None of the 4 results ever appear, and a subsequent transaction emerges after 6 cycles.
- Parameter sweep:
  - Stimulus: LOG_N ∈ {1,2,5}, WIDTH ∈ {1,8,32}, 1000 random vectors each, both modes.
  - Required response: latency = S, and output matches a stable sort of {key, lane}.
